// File: rtl/video_pll_sequencer.sv
// Video PLL power-up/run-time sequencer: PLL reset, lock qualification with retry/fail, pixel-clock switch.
// Optional lock-loss statistics enabled by defining VIDEO_PLL_SEQ_LOCK_STATS_EN.
module video_pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_STABLE   = 1024,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int MAX_RETRIES   = 3,
  parameter int DRAIN_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 64,
  parameter int DEFAULT_MODE  = 1
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic [1:0] clk_sel,
  output logic       video_rst_n,
  input  logic       mode_req_valid,
  input  logic [1:0] mode_req,
  output logic       mode_req_ready,
  output logic       mode_ack,
  output logic       mode_err,
  output logic       pll_fail,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(RST_CYCLES, LOCK_STABLE), LOCK_TIMEOUT),
                                max2(DRAIN_CYCLES, SETTLE_CYCLES));
  // +1 so DRAIN/SETTLE terminal values still fit when they are the largest count.
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   retry_q;
  logic [1:0]      pending_q;
  logic [1:0]      clk_sel_q;
  logic            pll_rst_q, video_rst_n_q, ready_q, ack_q, err_q, fail_q;
  logic [1:0]      rst_sync_q;
  logic            lock_meta_q, locked_s_q;
  logic            rst_ok;
  logic            lock_loss;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q  <= 2'b00;
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
    end else begin
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      lock_meta_q <= pll_locked;
      locked_s_q  <= lock_meta_q;
    end
  end

  assign rst_ok    = rst_sync_q[1];
  assign lock_loss = !locked_s_q && (state_q inside {ST_RUN, ST_DRAIN, ST_SETTLE});

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RST_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      pending_q     <= 2'(DEFAULT_MODE);
      clk_sel_q     <= 2'(DEFAULT_MODE);
      pll_rst_q     <= 1'b1;
      video_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      fail_q        <= 1'b0;
    end else if (rst_ok) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= cnt_q + CW'(1);
      if (lock_loss) begin
        // Abandon any pending switch; clk_sel stays on the clock already in use.
        state_q       <= ST_RST_PLL;
        cnt_q         <= '0;
        pll_rst_q     <= 1'b1;
        video_rst_n_q <= 1'b0;
        ready_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_RST_PLL: begin
            if (cnt_q == CW'(RST_CYCLES - 1)) begin
              state_q   <= ST_WAIT_LOCK;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked_s_q) begin
              state_q <= ST_QUALIFY;
              cnt_q   <= '0;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
              cnt_q     <= '0;
              pll_rst_q <= 1'b1;
              retry_q   <= retry_q + RW'(1);
              if (retry_q >= RW'(MAX_RETRIES)) begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q <= ST_RST_PLL;
              end
            end
          end
          ST_QUALIFY: begin
            if (!locked_s_q) begin
              state_q <= ST_WAIT_LOCK;
              cnt_q   <= '0;
            end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
              state_q       <= ST_RUN;
              cnt_q         <= '0;
              retry_q       <= '0;
              video_rst_n_q <= 1'b1;
              ready_q       <= 1'b1;
            end
          end
          ST_RUN: begin
            cnt_q <= '0;
            if (mode_req_valid && ready_q) begin
              if (mode_req == 2'd3) begin
                err_q <= 1'b1;
              end else if (mode_req == clk_sel_q) begin
                ack_q <= 1'b1;
              end else begin
                pending_q     <= mode_req;
                state_q       <= ST_DRAIN;
                video_rst_n_q <= 1'b0;
                ready_q       <= 1'b0;
              end
            end
          end
          ST_DRAIN: begin
            if (cnt_q == CW'(DRAIN_CYCLES)) begin
              clk_sel_q <= pending_q;
              state_q   <= ST_SETTLE;
              cnt_q     <= '0;
            end
          end
          ST_SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES)) begin
              state_q       <= ST_RUN;
              cnt_q         <= '0;
              video_rst_n_q <= 1'b1;
              ready_q       <= 1'b1;
              ack_q         <= 1'b1;
            end
          end
          ST_FAIL: begin
            cnt_q         <= cnt_q;
            pll_rst_q     <= 1'b1;
            video_rst_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b1;
          end
          default: begin
            state_q   <= ST_RST_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef VIDEO_PLL_SEQ_LOCK_STATS_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else if (rst_ok && lock_loss && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst        = pll_rst_q;
  assign clk_sel        = clk_sel_q;
  assign video_rst_n    = video_rst_n_q;
  assign mode_req_ready = ready_q;
  assign mode_ack       = ack_q;
  assign mode_err       = err_q;
  assign pll_fail       = fail_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_video_pll_sequencer.sv
// Directed bench for video_pll_sequencer with shortened timing parameters.
module tb_video_pll_sequencer;
  localparam int RST_C = 4, STABLE_C = 8, TMO_C = 100, RETRY_C = 2, DRAIN_C = 4, SETTLE_C = 4;

`ifdef VIDEO_PLL_SEQ_LOCK_STATS_EN
  localparam logic [7:0] LOSS_EXP = 8'd1;
`else
  localparam logic [7:0] LOSS_EXP = 8'd0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       mode_req_valid = 1'b0;
  logic [1:0] mode_req = 2'd0;
  logic       pll_rst, video_rst_n, mode_req_ready, mode_ack, mode_err, pll_fail;
  logic [1:0] clk_sel;
  logic [2:0] seq_state;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  video_pll_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_STABLE(STABLE_C), .LOCK_TIMEOUT(TMO_C), .MAX_RETRIES(RETRY_C),
    .DRAIN_CYCLES(DRAIN_C), .SETTLE_CYCLES(SETTLE_C), .DEFAULT_MODE(1)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .clk_sel(clk_sel), .video_rst_n(video_rst_n), .mode_req_valid(mode_req_valid),
    .mode_req(mode_req), .mode_req_ready(mode_req_ready), .mode_ack(mode_ack),
    .mode_err(mode_err), .pll_fail(pll_fail), .seq_state(seq_state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic req(input logic [1:0] m);
    mode_req_valid = 1'b1;
    mode_req = m;
    cyc(1);
    mode_req_valid = 1'b0;
  endtask

  initial begin
    int n;
    int falls;
    int sel_edge;
    logic prev;
    logic seen;

    rst_n = 1'b0;
    cyc(3);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_clk_sel", clk_sel, 1);
    check("rst_video_rst_n", video_rst_n, 0);
    check("rst_ready", mode_req_ready, 0);
    check("rst_ack", mode_ack, 0);
    check("rst_err", mode_err, 0);
    check("rst_pll_fail", pll_fail, 0);
    check("rst_loss_cnt", lock_loss_cnt, 0);
    check("rst_state", seq_state, 0);

    // No lock ever: three attempts then sticky FAIL.
    rst_n = 1'b1;
    n = 0; falls = 0; prev = 1'b1;
    while (!pll_fail && n < 1000) begin
      cyc(1);
      n++;
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
    end
    check("fail_cycles", n, 2 + (RETRY_C + 1) * (RST_C + TMO_C));
    check("fail_attempts", falls, RETRY_C + 1);
    check("fail_pll_rst", pll_rst, 1);
    check("fail_video_rst_n", video_rst_n, 0);
    check("fail_state", seq_state, 6);
    cyc(20);
    check("fail_sticky", pll_fail, 1);
    check("fail_state_hold", seq_state, 6);

    // Async reset clears FAIL without a clock edge.
    @(negedge refclk);
    rst_n = 1'b0;
    #1;
    check("arst_fail_clear", pll_fail, 0);
    check("arst_state", seq_state, 0);
    cyc(2);
    rst_n = 1'b1;

    // Power-up with lock arriving 10 cycles after reset release.
    cyc(5);
    check("pu_pll_rst_held", pll_rst, 1);
    cyc(1);
    check("pu_pll_rst_rel", pll_rst, 0);
    check("pu_wait_lock", seq_state, 1);
    cyc(4);
    pll_locked = 1'b1;
    n = 0;
    while (!video_rst_n && n < 40) begin
      cyc(1);
      n++;
    end
    check("pu_lock_latency", n, 2 + 1 + STABLE_C);
    check("pu_ready", mode_req_ready, 1);
    check("pu_state_run", seq_state, 3);

    // Switch to mode 0.
    req(2'd0);
    check("sw_vrst_low", video_rst_n, 0);
    check("sw_ready_drop", mode_req_ready, 0);
    check("sw_state_drain", seq_state, 4);
    n = 0; seen = 1'b0; sel_edge = 0;
    while (!mode_ack && n < 30) begin
      cyc(1);
      n++;
      if (clk_sel == 2'd0 && sel_edge == 0) sel_edge = n;
      if (video_rst_n && !mode_ack) seen = 1'b1;
    end
    check("sw_ack_latency", n, DRAIN_C + SETTLE_C + 2);
    check("sw_clk_sel_edge", sel_edge, DRAIN_C + 1);
    check("sw_vrst_early", seen, 0);
    check("sw_clk_sel", clk_sel, 0);
    check("sw_vrst_rel", video_rst_n, 1);
    cyc(1);
    check("sw_ack_single", mode_ack, 0);
    check("sw_state_run", seq_state, 3);

    // Invalid mode is rejected in place.
    req(2'd3);
    check("err_pulse", mode_err, 1);
    check("err_no_ack", mode_ack, 0);
    cyc(1);
    check("err_single", mode_err, 0);
    check("err_clk_sel", clk_sel, 0);
    check("err_state", seq_state, 3);
    check("err_vrst", video_rst_n, 1);

    // Same mode: immediate ack, no drain.
    req(2'd0);
    check("same_ack", mode_ack, 1);
    check("same_state", seq_state, 3);
    cyc(1);
    check("same_ack_single", mode_ack, 0);
    check("same_vrst", video_rst_n, 1);

    // One-cycle lock drop during DRAIN.
    req(2'd2);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    cyc(2);
    check("loss_state", seq_state, 0);
    check("loss_vrst", video_rst_n, 0);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_clk_sel", clk_sel, 0);
    check("loss_cnt", lock_loss_cnt, LOSS_EXP);
    n = 0; seen = 1'b0;
    while (seq_state != 3'd3 && n < 60) begin
      cyc(1);
      n++;
      if (mode_ack) seen = 1'b1;
    end
    check("relock_run", seq_state, 3);
    check("relock_no_ack", seen, 0);
    check("relock_clk_sel", clk_sel, 0);
    check("relock_vrst", video_rst_n, 1);

    // Reset asserted during SETTLE.
    req(2'd2);
    n = 0;
    while (seq_state != 3'd5 && n < 20) begin
      cyc(1);
      n++;
    end
    check("settle_reached", seq_state, 5);
    check("settle_clk_sel", clk_sel, 2);
    rst_n = 1'b0;
    #1;
    check("mid_pll_rst", pll_rst, 1);
    check("mid_clk_sel", clk_sel, 1);
    check("mid_vrst", video_rst_n, 0);
    check("mid_ready", mode_req_ready, 0);
    check("mid_ack", mode_ack, 0);
    check("mid_err", mode_err, 0);
    check("mid_fail", pll_fail, 0);
    check("mid_loss_cnt", lock_loss_cnt, 0);
    check("mid_state", seq_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
